// File: rtl/stage6_pkg.sv
// stage6_pkg: shared state encoding, default word format and the
// shift-and-saturate helper used by every lane datapath.
package stage6_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_FRAC  = 8;

   // Widest intermediate the helper accepts; covers 2*WIDTH+1 for WIDTH up to 32.
   localparam int WIDE = 65;

   typedef enum logic [1:0] {IDLE, ACCUM, NORM, OUT} state_t;

   // Arithmetic (floor) shift right by frac, then clamp to a signed width-bit range.
   function automatic logic signed [WIDE-1:0] sat_shift(
      input logic signed [WIDE-1:0] value,
      input int                     width,
      input int                     frac
   );
      logic signed [WIDE-1:0] shifted;
      logic signed [WIDE-1:0] max_v;
      logic signed [WIDE-1:0] min_v;
      shifted = value >>> frac;
      max_v   = (WIDE'(1) <<< (width - 1)) - WIDE'(1);
      min_v   = -(WIDE'(1) <<< (width - 1));
      if (shifted > max_v)
         sat_shift = max_v;
      else if (shifted < min_v)
         sat_shift = min_v;
      else
         sat_shift = shifted;
   endfunction

endpackage

// File: rtl/stage6_lane_mac.sv
// stage6_lane_mac: combinational datapath for one lane. Produces the
// rescaled accumulator update and the beta-normalised result.
module stage6_lane_mac
   import stage6_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC
)(
   input  logic signed [WIDTH-1:0] acc,
   input  logic signed [WIDTH-1:0] alpha,
   input  logic signed [WIDTH-1:0] one_m_alpha,
   input  logic signed [WIDTH-1:0] v,
   input  logic signed [WIDTH-1:0] beta_cap,
   output logic signed [WIDTH-1:0] upd,
   output logic signed [WIDTH-1:0] norm
);

   logic signed [2*WIDTH-1:0] hist_prod;
   logic signed [2*WIDTH-1:0] new_prod;
   logic signed [2*WIDTH-1:0] norm_prod;
   logic signed [2*WIDTH:0]   upd_sum;
   logic signed [WIDE-1:0]    upd_wide;
   logic signed [WIDE-1:0]    norm_wide;

   // Full-precision products and sum, then one shared shift/saturate step each.
   always_comb begin
      hist_prod = (2*WIDTH)'(acc) * (2*WIDTH)'(one_m_alpha);
      new_prod  = (2*WIDTH)'(alpha) * (2*WIDTH)'(v);
      upd_sum   = (2*WIDTH+1)'(hist_prod) + (2*WIDTH+1)'(new_prod);
      norm_prod = (2*WIDTH)'(acc) * (2*WIDTH)'(beta_cap);
      upd_wide  = WIDE'(upd_sum);
      norm_wide = WIDE'(norm_prod);
      upd       = WIDTH'(sat_shift(upd_wide, WIDTH, FRAC));
      norm      = WIDTH'(sat_shift(norm_wide, WIDTH, FRAC));
   end

endmodule

// File: rtl/pipe_stage6_accum.sv
// pipe_stage6_accum: per-lane running rescale accumulator fed by stage 5.
// Accumulates U = U*(1-alpha) + alpha*V over a sequence, normalises by the
// beta captured on the last beat and presents the result on valid/ready.
module pipe_stage6_accum
   import stage6_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int FRAC          = DEF_FRAC,
   parameter int para          = 8,
   parameter int parallel_size = 2
)(
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start_i,
   input  logic [para-1:0]                       J_size,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [parallel_size-1:0][WIDTH-1:0]   alpha_i,
   input  logic [parallel_size-1:0][WIDTH-1:0]   one_m_alpha_i,
   input  logic [parallel_size-1:0][WIDTH-1:0]   beta_i,
   input  logic [parallel_size-1:0][WIDTH-1:0]   v_i,
   input  logic [parallel_size-1:0]              U_add,
   input  logic                                  finished_i,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [parallel_size-1:0][WIDTH-1:0]   out_data,
   output logic [para-1:0]                       beat_cnt_o,
   output logic                                  busy,
   output logic                                  done_o
);

   localparam logic [para-1:0] CNT_MAX = '1;

   state_t                              state;
   logic [parallel_size-1:0][WIDTH-1:0] acc;
   logic [parallel_size-1:0][WIDTH-1:0] beta_cap;
   logic [parallel_size-1:0][WIDTH-1:0] upd;
   logic [parallel_size-1:0][WIDTH-1:0] norm;
   logic                                beat_acc;
   logic                                count_hit;
   logic                                last_beat;

   for (genvar l = 0; l < parallel_size; l++) begin : g_lane
      stage6_lane_mac #(
         .WIDTH (WIDTH),
         .FRAC  (FRAC)
      ) u_lane (
         .acc         (acc[l]),
         .alpha       (alpha_i[l]),
         .one_m_alpha (one_m_alpha_i[l]),
         .v           (v_i[l]),
         .beta_cap    (beta_cap[l]),
         .upd         (upd[l]),
         .norm        (norm[l])
      );
   end

   assign in_ready  = (state == ACCUM);
   assign busy      = (state != IDLE);
   assign done_o    = out_valid & out_ready;
   assign beat_acc  = in_valid & in_ready;
   assign count_hit = (J_size != '0) &&
                      ((para+1)'(beat_cnt_o) + (para+1)'(1) == (para+1)'(J_size));
   assign last_beat = finished_i | count_hit;

   // Sequence FSM: accumulate beats, normalise once, then hold the result
   // for the consumer. out_valid rises one cycle after out_data is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         acc        <= '0;
         beta_cap   <= '0;
         out_data   <= '0;
         beat_cnt_o <= '0;
         out_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  acc        <= '0;
                  beat_cnt_o <= '0;
                  state      <= ACCUM;
               end
            end
            ACCUM: begin
               if (beat_acc) begin
                  for (int l = 0; l < parallel_size; l++) begin
                     if (U_add[l])
                        acc[l] <= upd[l];
                  end
                  if (beat_cnt_o != CNT_MAX)
                     beat_cnt_o <= beat_cnt_o + para'(1);
                  if (last_beat) begin
                     beta_cap <= beta_i;
                     state    <= NORM;
                  end
               end
            end
            NORM: begin
               out_data <= norm;
               state    <= OUT;
            end
            OUT: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage6_accum.sv
// tb_pipe_stage6_accum: directed self-checking bench for pipe_stage6_accum.
module tb_pipe_stage6_accum;

   localparam int WIDTH = 16;
   localparam int FRAC  = 8;
   localparam int PARA  = 8;
   localparam int PS    = 2;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        start_i;
   logic [PARA-1:0]             J_size;
   logic                        in_valid;
   logic                        in_ready;
   logic [PS-1:0][WIDTH-1:0]    alpha_i;
   logic [PS-1:0][WIDTH-1:0]    one_m_alpha_i;
   logic [PS-1:0][WIDTH-1:0]    beta_i;
   logic [PS-1:0][WIDTH-1:0]    v_i;
   logic [PS-1:0]               U_add;
   logic                        finished_i;
   logic                        out_valid;
   logic                        out_ready;
   logic [PS-1:0][WIDTH-1:0]    out_data;
   logic [PARA-1:0]             beat_cnt_o;
   logic                        busy;
   logic                        done_o;

   int checks   = 0;
   int failures = 0;

   pipe_stage6_accum #(
      .WIDTH         (WIDTH),
      .FRAC          (FRAC),
      .para          (PARA),
      .parallel_size (PS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .J_size        (J_size),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .alpha_i       (alpha_i),
      .one_m_alpha_i (one_m_alpha_i),
      .beta_i        (beta_i),
      .v_i           (v_i),
      .U_add         (U_add),
      .finished_i    (finished_i),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .beat_cnt_o    (beat_cnt_o),
      .busy          (busy),
      .done_o        (done_o)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_seq();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic beat(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] m0,
                       input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] a1,
                       input logic [WIDTH-1:0] m1, input logic [WIDTH-1:0] v1,
                       input logic [WIDTH-1:0] b0, input logic [WIDTH-1:0] b1,
                       input logic [PS-1:0] ua, input logic fin);
      alpha_i       = {a1, a0};
      one_m_alpha_i = {m1, m0};
      v_i           = {v1, v0};
      beta_i        = {b1, b0};
      U_add         = ua;
      finished_i    = fin;
      in_valid      = 1'b1;
      step();
      in_valid      = 1'b0;
      finished_i    = 1'b0;
   endtask

   task automatic accept_output();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({in_ready, busy, out_valid, done_o} !== 4'b0000 || beat_cnt_o !== '0 || out_data !== '0) begin
         failures++;
         $display("[TB] FAIL reset_outputs got=%b cnt=%h data=%h exp=0000 cnt=00 data=0",
                  {in_ready, busy, out_valid, done_o}, beat_cnt_o, out_data);
      end
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      J_size = '0;
      start_seq();
      beat(16'h0080, 16'h0080, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0200, 16'h0, 2'b01, 1'b0);
      checks++;
      if (dut.acc[0] !== 16'h0100 || beat_cnt_o !== 8'd1) begin
         failures++;
         $display("[TB] FAIL basic_beat1 got acc=%h cnt=%0d exp acc=0100 cnt=1", dut.acc[0], beat_cnt_o);
      end
      beat(16'h0080, 16'h0080, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0200, 16'h0, 2'b01, 1'b1);
      checks++;
      if (dut.acc[0] !== 16'h0180 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_beat2 got acc=%h rdy=%b vld=%b exp acc=0180 rdy=0 vld=0",
                  dut.acc[0], in_ready, out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_latency_early got=%b exp=0", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== {16'h0000, 16'h0300}) begin
         failures++;
         $display("[TB] FAIL basic_result got vld=%b data=%h exp vld=1 data=00000300", out_valid, out_data);
      end
   endtask

   task automatic test_backpressure();
      int done_count;
      done_count = 0;
      out_ready  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== {16'h0000, 16'h0300} || done_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_hold_%0d got vld=%b data=%h done=%b exp vld=1 data=00000300 done=0",
                     i, out_valid, out_data, done_o);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      if (done_o === 1'b1) done_count++;
      step();
      out_ready = 1'b0;
      if (done_o === 1'b1) done_count++;
      checks++;
      if (done_count !== 1) begin
         failures++;
         $display("[TB] FAIL bp_done_pulses got=%0d exp=1", done_count);
      end
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== {16'h0000, 16'h0300}) begin
         failures++;
         $display("[TB] FAIL bp_after got busy=%b vld=%b data=%h exp busy=0 vld=0 data=00000300",
                  busy, out_valid, out_data);
      end
   endtask

   task automatic test_saturation();
      start_seq();
      beat(16'h0100, 16'h0000, 16'h7000, 16'h0100, 16'h0000, 16'h9000, 16'h0100, 16'h0100, 2'b11, 1'b0);
      checks++;
      if (dut.acc !== {16'h9000, 16'h7000}) begin
         failures++;
         $display("[TB] FAIL sat_preload got=%h exp=90007000", dut.acc);
      end
      beat(16'h0100, 16'h0100, 16'h7000, 16'h0100, 16'h0100, 16'h9000, 16'h0100, 16'h0100, 2'b11, 1'b1);
      step();
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== {16'h8000, 16'h7FFF}) begin
         failures++;
         $display("[TB] FAIL sat_result got vld=%b data=%h exp vld=1 data=80007fff", out_valid, out_data);
      end
      accept_output();
   endtask

   task automatic test_jsize();
      J_size = 8'd3;
      start_seq();
      beat(16'h0100, 16'h0000, 16'h0010, 16'h0080, 16'h0000, 16'hFFFF, 16'h0300, 16'h0080, 2'b11, 1'b0);
      checks++;
      if (beat_cnt_o !== 8'd1 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL jsize_beat1 got cnt=%0d rdy=%b exp cnt=1 rdy=1", beat_cnt_o, in_ready);
      end
      beat(16'h0100, 16'h0000, 16'h0020, 16'h0080, 16'h0000, 16'hFFFF, 16'h0300, 16'h0080, 2'b11, 1'b0);
      beat(16'h0100, 16'h0000, 16'h0040, 16'h0080, 16'h0000, 16'hFFFF, 16'h0300, 16'h0080, 2'b11, 1'b0);
      checks++;
      if (beat_cnt_o !== 8'd3 || in_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL jsize_term got cnt=%0d rdy=%b busy=%b exp cnt=3 rdy=0 busy=1",
                  beat_cnt_o, in_ready, busy);
      end
      step();
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== {16'hFFFF, 16'h00C0}) begin
         failures++;
         $display("[TB] FAIL jsize_result got vld=%b data=%h exp vld=1 data=ffff00c0", out_valid, out_data);
      end
      accept_output();
      J_size = '0;
   endtask

   task automatic test_reset_mid();
      start_seq();
      beat(16'h0080, 16'h0080, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 2'b01, 1'b0);
      beat(16'h0080, 16'h0080, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 2'b01, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, busy, out_valid, done_o} !== 4'b0000 || beat_cnt_o !== '0 ||
          out_data !== '0 || dut.acc !== '0) begin
         failures++;
         $display("[TB] FAIL rst_mid got=%b cnt=%h data=%h acc=%h exp=0000 cnt=00 data=0 acc=0",
                  {in_ready, busy, out_valid, done_o}, beat_cnt_o, out_data, dut.acc);
      end
      step();
      rst        = 1'b0;
      in_valid   = 1'b1;
      finished_i = 1'b1;
      step();
      step();
      in_valid   = 1'b0;
      finished_i = 1'b0;
      checks++;
      if (busy !== 1'b0 || beat_cnt_o !== 8'd0) begin
         failures++;
         $display("[TB] FAIL rst_idle_ignore got busy=%b cnt=%0d exp busy=0 cnt=0", busy, beat_cnt_o);
      end
      start_seq();
      beat(16'h0080, 16'h0100, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 2'b01, 1'b1);
      checks++;
      if (dut.acc[0] !== 16'h0100) begin
         failures++;
         $display("[TB] FAIL rst_fresh_acc got=%h exp=0100", dut.acc[0]);
      end
      step();
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data[0] !== 16'h0100) begin
         failures++;
         $display("[TB] FAIL rst_fresh_result got vld=%b data0=%h exp vld=1 data0=0100", out_valid, out_data[0]);
      end
      accept_output();
   endtask

   task automatic test_ignored();
      in_valid   = 1'b1;
      finished_i = 1'b1;
      v_i        = {16'h0, 16'h0400};
      alpha_i    = {16'h0, 16'h0100};
      U_add      = 2'b01;
      step();
      step();
      checks++;
      if (busy !== 1'b0 || beat_cnt_o !== 8'd1) begin
         failures++;
         $display("[TB] FAIL ign_idle got busy=%b cnt=%0d exp busy=0 cnt=1", busy, beat_cnt_o);
      end
      finished_i = 1'b0;
      start_seq();
      in_valid   = 1'b0;
      checks++;
      if (beat_cnt_o !== 8'd0 || dut.acc[0] !== 16'h0000 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ign_start_beat got cnt=%0d acc=%h rdy=%b exp cnt=0 acc=0000 rdy=1",
                  beat_cnt_o, dut.acc[0], in_ready);
      end
      beat(16'h0100, 16'h0000, 16'h0050, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 2'b01, 1'b0);
      start_i    = 1'b1;
      finished_i = 1'b1;
      step();
      start_i    = 1'b0;
      finished_i = 1'b0;
      checks++;
      if (beat_cnt_o !== 8'd1 || dut.acc[0] !== 16'h0050 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ign_accum got cnt=%0d acc=%h rdy=%b exp cnt=1 acc=0050 rdy=1",
                  beat_cnt_o, dut.acc[0], in_ready);
      end
      beat(16'h0000, 16'h0100, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 2'b01, 1'b1);
      step();
      step();
      in_valid   = 1'b1;
      finished_i = 1'b1;
      step();
      step();
      in_valid   = 1'b0;
      finished_i = 1'b0;
      checks++;
      if (beat_cnt_o !== 8'd2 || out_valid !== 1'b1 || out_data[0] !== 16'h0050) begin
         failures++;
         $display("[TB] FAIL ign_out got cnt=%0d vld=%b data0=%h exp cnt=2 vld=1 data0=0050",
                  beat_cnt_o, out_valid, out_data[0]);
      end
      accept_output();
   endtask

   // Main sequence: reset, then each scenario in turn, then the summary.
   initial begin
      rst           = 1'b1;
      start_i       = 1'b0;
      J_size        = '0;
      in_valid      = 1'b0;
      alpha_i       = '0;
      one_m_alpha_i = '0;
      beta_i        = '0;
      v_i           = '0;
      U_add         = '0;
      finished_i    = 1'b0;
      out_ready     = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_saturation();
      test_jsize();
      test_reset_mid();
      test_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
